// File: rtl/vedacao_multi_if.sv
// Bus bundle for vedacao_multi: stock loading, per-station bottle sensors,
// seal/alarm strobes, counter levels and refill handshake.
interface vedacao_multi_if #(
  parameter int unsigned N_ST  = 2,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CH_W = (N_ST > 1) ? $clog2(N_ST) : 1;

  logic                    stock_load;
  logic [CNT_W-1:0]        stock_in;
  logic [N_ST-1:0]         gar;
  logic [N_ST-1:0]         pos;
  logic [N_ST-1:0]         ve;
  logic [N_ST-1:0]         done;
  logic [N_ST-1:0]         alarme;
  logic [N_ST*CNT_W-1:0]   mag_count;
  logic [CNT_W-1:0]        stock;
  logic                    refill_valid;
  logic [CH_W-1:0]         refill_ch;

  modport master (
    output stock_load, stock_in, gar, pos,
    input  ve, done, alarme, mag_count, stock, refill_valid, refill_ch
  );

  modport slave (
    input  stock_load, stock_in, gar, pos,
    output ve, done, alarme, mag_count, stock, refill_valid, refill_ch
  );
endinterface

// File: rtl/vedacao_multi.sv
// Multi-station capping controller: per-station seal FSMs plus a shared-stock refill arbiter.
// Define VEDACAO_RR_ARB_EN for round-robin arbitration; otherwise lowest station index wins.
module vedacao_multi #(
  parameter int unsigned N_ST       = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MAG_DEPTH  = 15,
  parameter int unsigned REFILL_LVL = 5
) (
  input  logic            clk,
  input  logic            reset,
  vedacao_multi_if.slave  bus
);
  localparam int unsigned CH_W = (N_ST > 1) ? $clog2(N_ST) : 1;
  localparam logic [CNT_W-1:0] MAG_MAX   = CNT_W'(MAG_DEPTH);
  localparam logic [CNT_W-1:0] LVL       = CNT_W'(REFILL_LVL);
  localparam logic [CNT_W:0]   STOCK_SAT = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SEAL, DONE, ALARM} state_t;

  state_t           st_q  [N_ST];
  state_t           st_d  [N_ST];
  logic [CNT_W-1:0] mag_q [N_ST];
  logic [CNT_W-1:0] mag_d [N_ST];
  logic [CNT_W-1:0] stock_q, stock_d;
  logic [CNT_W:0]   stock_sum_c;
  logic [CNT_W-1:0] room_c, amt_c;
  logic [N_ST-1:0]  req_c;
  logic             grant_vld_c;
  logic [CH_W-1:0]  grant_idx_c;

  logic [N_ST-1:0]       ve_q, done_q, alarme_q;
  logic                  refill_valid_q;
  logic [CH_W-1:0]       refill_ch_q;
  logic [N_ST*CNT_W-1:0] mag_count_c;

  // A station asks for corks once its magazine is at or below the refill level.
  always_comb begin
    req_c = '0;
    for (int i = 0; i < N_ST; i++) begin
      req_c[i] = (mag_q[i] <= LVL) && (stock_q != '0);
    end
  end

`ifdef VEDACAO_RR_ARB_EN
  logic [CH_W-1:0] ptr_q;
  int              rr_idx;

  // Search starts at the pointer; descending offsets so the nearest requester wins.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    rr_idx      = 0;
    for (int k = N_ST - 1; k >= 0; k--) begin
      rr_idx = (int'(ptr_q) + k) % int'(N_ST);
      if (req_c[rr_idx]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = CH_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (grant_vld_c) begin
      ptr_q <= (int'(grant_idx_c) == int'(N_ST) - 1) ? '0 : grant_idx_c + CH_W'(1);
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int k = N_ST - 1; k >= 0; k--) begin
      if (req_c[k]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = CH_W'(k);
      end
    end
  end
`endif

  // Transfer size and stock update; stock never wraps.
  always_comb begin
    room_c = MAG_MAX - mag_q[grant_idx_c];
    amt_c  = '0;
    if (grant_vld_c) begin
      amt_c = (stock_q < room_c) ? stock_q : room_c;
    end
    stock_sum_c = {1'b0, stock_q} - {1'b0, amt_c}
                + (bus.stock_load ? {1'b0, bus.stock_in} : '0);
    stock_d = (stock_sum_c > STOCK_SAT) ? '1 : stock_sum_c[CNT_W-1:0];
  end

  // Per-station seal FSM next state and magazine update.
  always_comb begin
    for (int i = 0; i < N_ST; i++) begin
      st_d[i]  = st_q[i];
      mag_d[i] = mag_q[i];
      case (st_q[i])
        IDLE:  if (bus.gar[i] && bus.pos[i]) st_d[i] = (mag_q[i] != '0) ? SEAL : ALARM;
        SEAL:  st_d[i] = DONE;
        DONE:  if (!bus.gar[i]) st_d[i] = IDLE;
        ALARM: begin
          if (!bus.gar[i])                          st_d[i] = IDLE;
          else if (bus.pos[i] && mag_q[i] != '0)    st_d[i] = SEAL;
        end
        default: st_d[i] = IDLE;
      endcase
      if (grant_vld_c && grant_idx_c == CH_W'(i)) mag_d[i] = mag_d[i] + amt_c;
      if (st_q[i] == SEAL)                        mag_d[i] = mag_d[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ST; i++) begin
        st_q[i]  <= IDLE;
        mag_q[i] <= '0;
      end
      stock_q        <= '0;
      ve_q           <= '0;
      done_q         <= '0;
      alarme_q       <= '0;
      refill_valid_q <= 1'b0;
      refill_ch_q    <= '0;
    end else begin
      for (int i = 0; i < N_ST; i++) begin
        st_q[i]     <= st_d[i];
        mag_q[i]    <= mag_d[i];
        ve_q[i]     <= (st_d[i] == SEAL);
        done_q[i]   <= (st_d[i] == DONE);
        alarme_q[i] <= (st_d[i] == ALARM);
      end
      stock_q        <= stock_d;
      refill_valid_q <= grant_vld_c;
      refill_ch_q    <= grant_vld_c ? grant_idx_c : '0;
    end
  end

  always_comb begin
    mag_count_c = '0;
    for (int i = 0; i < N_ST; i++) begin
      mag_count_c[i*CNT_W +: CNT_W] = mag_q[i];
    end
  end

  assign bus.ve           = ve_q;
  assign bus.done         = done_q;
  assign bus.alarme       = alarme_q;
  assign bus.mag_count    = mag_count_c;
  assign bus.stock        = stock_q;
  assign bus.refill_valid = refill_valid_q;
  assign bus.refill_ch    = refill_ch_q;
endmodule

// File: tb/tb_vedacao_multi.sv
// Bench for vedacao_multi: directed line scenarios followed by random bottle/stock traffic,
// all compared every cycle against a cycle-level reference model of the stations and stock.
`timescale 1ns/1ps
module tb_vedacao_multi;
  localparam int N_ST       = 2;
  localparam int CNT_W      = 8;
  localparam int MAG_DEPTH  = 15;
  localparam int REFILL_LVL = 5;
  localparam int SAT        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vedacao_multi_if #(.N_ST(N_ST), .CNT_W(CNT_W)) bus ();

  vedacao_multi #(
    .N_ST(N_ST), .CNT_W(CNT_W), .MAG_DEPTH(MAG_DEPTH), .REFILL_LVL(REFILL_LVL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: station mode is 'I'dle, 'S'ealing, 'D'one or 'A'larm.
  byte m_mode [N_ST];
  int  m_mag  [N_ST];
  int  m_stock;
  int  m_ptr;
  int  m_rv;
  int  m_rch;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag_of(input int i);
    return 32'(bus.mag_count[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_ST; i++) begin
      m_mode[i] = "I";
      m_mag[i]  = 0;
    end
    m_stock = 0;
    m_ptr   = 0;
    m_rv    = 0;
    m_rch   = 0;
  endtask

  task automatic model_step(input logic [N_ST-1:0] g, input logic [N_ST-1:0] p,
                            input logic ld, input int sin);
    int  win;
    int  amt;
    int  s;
    byte nmode [N_ST];
    int  nmag  [N_ST];
    win = -1;
    amt = 0;
    if (m_stock > 0) begin
      for (int k = 0; k < N_ST; k++) begin
`ifdef VEDACAO_RR_ARB_EN
        s = (m_ptr + k) % N_ST;
`else
        s = k;
`endif
        if (win < 0 && m_mag[s] <= REFILL_LVL) win = s;
      end
    end
    if (win >= 0) amt = (m_stock < MAG_DEPTH - m_mag[win]) ? m_stock : MAG_DEPTH - m_mag[win];
    for (int i = 0; i < N_ST; i++) begin
      nmode[i] = m_mode[i];
      if (m_mode[i] == "I" && g[i] && p[i]) nmode[i] = (m_mag[i] > 0) ? "S" : "A";
      else if (m_mode[i] == "S")            nmode[i] = "D";
      else if (m_mode[i] == "D" && !g[i])   nmode[i] = "I";
      else if (m_mode[i] == "A") begin
        if (!g[i])                     nmode[i] = "I";
        else if (p[i] && m_mag[i] > 0) nmode[i] = "S";
      end
      nmag[i] = m_mag[i] + ((i == win) ? amt : 0) - ((m_mode[i] == "S") ? 1 : 0);
    end
    for (int i = 0; i < N_ST; i++) begin
      m_mode[i] = nmode[i];
      m_mag[i]  = nmag[i];
    end
    m_stock = m_stock - amt + (ld ? sin : 0);
    if (m_stock > SAT) m_stock = SAT;
    m_rv  = (win >= 0) ? 1 : 0;
    m_rch = (win >= 0) ? win : 0;
    if (win >= 0) m_ptr = (win + 1) % N_ST;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N_ST; i++) begin
      check($sformatf("ve%0d", i),     32'(bus.ve[i]),     (m_mode[i] == "S") ? 1 : 0);
      check($sformatf("done%0d", i),   32'(bus.done[i]),   (m_mode[i] == "D") ? 1 : 0);
      check($sformatf("alarme%0d", i), 32'(bus.alarme[i]), (m_mode[i] == "A") ? 1 : 0);
      check($sformatf("mag%0d", i),    mag_of(i),          m_mag[i]);
    end
    check("stock",        32'(bus.stock),        m_stock);
    check("refill_valid", 32'(bus.refill_valid), m_rv);
    if (m_rv != 0) check("refill_ch", 32'(bus.refill_ch), m_rch);
  endtask

  task automatic tick();
    model_step(bus.gar, bus.pos, bus.stock_load, int'(bus.stock_in));
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic load(input int n);
    bus.stock_load = 1'b1;
    bus.stock_in   = CNT_W'(n);
    tick();
    bus.stock_load = 1'b0;
    bus.stock_in   = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 reset = 1'b1;
  endtask

  task automatic seal(input int i, input int n);
    repeat (n) begin
      bus.gar[i] = 1'b1;
      bus.pos[i] = 1'b1;
      tick();
      tick();
      bus.gar[i] = 1'b0;
      bus.pos[i] = 1'b0;
      tick();
    end
  endtask

  int exp_ch [4];

  initial begin
    bus.stock_load = 1'b0;
    bus.stock_in   = '0;
    bus.gar        = '0;
    bus.pos        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mag_count", 32'(bus.mag_count), 0);
    check("rst_stock",     32'(bus.stock), 0);
    check("rst_ve",        32'(bus.ve), 0);
    check("rst_done",      32'(bus.done), 0);
    check("rst_alarme",    32'(bus.alarme), 0);
    check("rst_rv",        32'(bus.refill_valid), 0);
    check("rst_rch",       32'(bus.refill_ch), 0);
    #3 reset = 1'b1;

    // Initial stock and the two magazine fills
    load(40);
    check("load40_stock", 32'(bus.stock), 40);
    tick();
    check("fill0_rv", 32'(bus.refill_valid), 1);
    check("fill0_ch", 32'(bus.refill_ch), 0);
    check("fill0_mag", mag_of(0), 15);
    check("fill0_stock", 32'(bus.stock), 25);
    tick();
    check("fill1_ch", 32'(bus.refill_ch), 1);
    check("fill1_mag", mag_of(1), 15);
    check("fill1_stock", 32'(bus.stock), 10);

    // Single seal on station 0
    bus.gar[0] = 1'b1;
    bus.pos[0] = 1'b1;
    tick();
    check("seal_ve", 32'(bus.ve[0]), 1);
    check("seal_mag_hold", mag_of(0), 15);
    tick();
    check("seal_ve_off", 32'(bus.ve[0]), 0);
    check("seal_done", 32'(bus.done[0]), 1);
    check("seal_mag", mag_of(0), 14);
    tick();
    tick();
    check("seal_done_hold", 32'(bus.done[0]), 1);
    bus.gar[0] = 1'b0;
    bus.pos[0] = 1'b0;
    tick();
    check("seal_idle", 32'(bus.done[0]), 0);

    // Alarm on empty magazine, cleared by a small refill
    do_reset();
    load(15);
    tick();
    check("alm_mag0", mag_of(0), 15);
    bus.gar[1] = 1'b1;
    bus.pos[1] = 1'b1;
    tick();
    check("alm_raise", 32'(bus.alarme[1]), 1);
    load(3);
    check("alm_hold", 32'(bus.alarme[1]), 1);
    tick();
    check("alm_fill_ch", 32'(bus.refill_ch), 1);
    check("alm_fill_mag", mag_of(1), 3);
    check("alm_fill_stock", 32'(bus.stock), 0);
    tick();
    check("alm_ve", 32'(bus.ve[1]), 1);
    check("alm_clear", 32'(bus.alarme[1]), 0);
    tick();
    check("alm_mag_after", mag_of(1), 2);
    bus.gar[1] = 1'b0;
    bus.pos[1] = 1'b0;
    tick();

    // Drain to the refill level, refill on the following cycle
    do_reset();
    load(30);
    tick();
    tick();
    seal(0, 9);
    check("drain_mag6", mag_of(0), 6);
    load(20);
    bus.gar[0] = 1'b1;
    bus.pos[0] = 1'b1;
    tick();
    tick();
    check("drain_mag5", mag_of(0), 5);
    tick();
    check("drain_fill_rv", 32'(bus.refill_valid), 1);
    check("drain_fill_mag", mag_of(0), 15);
    check("drain_fill_stock", 32'(bus.stock), 10);
    bus.gar[0] = 1'b0;
    bus.pos[0] = 1'b0;
    tick();

    // Refill and seal exit on the same edge
    do_reset();
    load(30);
    tick();
    tick();
    seal(0, 10);
    check("same_mag5", mag_of(0), 5);
    bus.gar[0] = 1'b1;
    bus.pos[0] = 1'b1;
    load(20);
    check("same_ve", 32'(bus.ve[0]), 1);
    tick();
    check("same_mag14", mag_of(0), 14);
    check("same_stock", 32'(bus.stock), 10);
    bus.gar[0] = 1'b0;
    bus.pos[0] = 1'b0;
    tick();

    // Stock saturation, then reset while sealing
    do_reset();
    load(30);
    tick();
    tick();
    load(250);
    check("sat_250", 32'(bus.stock), 250);
    load(10);
    check("sat_255", 32'(bus.stock), 255);
    bus.gar[0] = 1'b1;
    bus.pos[0] = 1'b1;
    tick();
    check("rst_seal_ve", 32'(bus.ve[0]), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_seal_ve0", 32'(bus.ve), 0);
    check("rst_seal_mag", 32'(bus.mag_count), 0);
    check("rst_seal_stock", 32'(bus.stock), 0);
    bus.gar[0] = 1'b0;
    bus.pos[0] = 1'b0;
    #1 reset = 1'b1;

    // Both stations requesting every cycle: trickle one cork per cycle
`ifdef VEDACAO_RR_ARB_EN
    exp_ch = '{0, 1, 0, 1};
`else
    exp_ch = '{0, 0, 0, 0};
`endif
    bus.stock_load = 1'b1;
    bus.stock_in   = CNT_W'(1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("arb_rv%0d", k), 32'(bus.refill_valid), 1);
      check($sformatf("arb_ch%0d", k), 32'(bus.refill_ch), exp_ch[k]);
    end
    bus.stock_load = 1'b0;
    bus.stock_in   = '0;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_ST; i++) begin
        if ($urandom_range(0, 5) == 0) bus.gar[i] = ~bus.gar[i];
        bus.pos[i] = bus.gar[i] & ($urandom_range(0, 3) != 0);
      end
      bus.stock_load = ($urandom_range(0, 11) == 0);
      bus.stock_in   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(200, 255))
                                                   : CNT_W'($urandom_range(0, 20));
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
